// File: rtl/mem_stage_pkg.sv
// Shared MEM-stage header: bus widths, load encodings, EXE->MEM layout.
// Optional MS_LWLR_EN (default: undefined) adds LWL/LWR and rt_value.
`ifndef MYCPU_H
`define MYCPU_H
`ifdef MS_LWLR_EN
`define ES_TO_MS_BUS_WD 106
`else
`define ES_TO_MS_BUS_WD 74
`endif
`define MS_TO_WS_BUS_WD 70
`define LD_LW  3'd0
`define LD_LB  3'd1
`define LD_LBU 3'd2
`define LD_LH  3'd3
`define LD_LHU 3'd4
`define LD_LWL 3'd5
`define LD_LWR 3'd6
`endif

package mem_stage_pkg;

  localparam int ES_TO_MS_BUS_WD = `ES_TO_MS_BUS_WD;
  localparam int MS_TO_WS_BUS_WD = `MS_TO_WS_BUS_WD;

  typedef struct packed {
    logic [2:0]  load_type;
    logic        res_from_mem;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] alu_result;
    logic [31:0] pc;
  } es_ms_t;

  typedef struct packed {
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] final_result;
    logic [31:0] pc;
  } ms_ws_t;

endpackage

// File: rtl/mem_stage_load_align.sv
// Load data extraction: byte/half select with sign or zero extension.
// LWL/LWR merge with rt is present only under MS_LWLR_EN.
module mem_stage_load_align
  import mem_stage_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [2:0]  load_type,
`ifdef MS_LWLR_EN
  input  logic [31:0] rt,
`endif
  output logic [31:0] load_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = 8'h00;
    unique case (addr)
      2'd0: byte_sel = rdata[7:0];
      2'd1: byte_sel = rdata[15:8];
      2'd2: byte_sel = rdata[23:16];
      2'd3: byte_sel = rdata[31:24];
      default: byte_sel = 8'h00;
    endcase
  end

  assign half_sel = addr[1] ? rdata[31:16]
                            : rdata[15:0];

  always_comb begin
    load_data = rdata;
    unique case (load_type)
      `LD_LW:  load_data = rdata;
      `LD_LB:  load_data = {{24{byte_sel[7]}},
                            byte_sel};
      `LD_LBU: load_data = {24'h0, byte_sel};
      `LD_LH:  load_data = {{16{half_sel[15]}},
                            half_sel};
      `LD_LHU: load_data = {16'h0, half_sel};
`ifdef MS_LWLR_EN
      `LD_LWL: begin
        unique case (addr)
          2'd0: load_data = {rdata[7:0], rt[23:0]};
          2'd1: load_data = {rdata[15:0], rt[15:0]};
          2'd2: load_data = {rdata[23:0], rt[7:0]};
          default: load_data = rdata;
        endcase
      end
      `LD_LWR: begin
        unique case (addr)
          2'd1: load_data = {rt[31:24], rdata[31:8]};
          2'd2: load_data = {rt[31:16], rdata[31:16]};
          2'd3: load_data = {rt[31:8], rdata[31:24]};
          default: load_data = rdata;
        endcase
      end
`endif
      default: load_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MIPS pipeline memory stage: load align, result select, WB handshake.
// MS_LWLR_EN widens the EXE bus with rt_value for LWL/LWR.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        ws_allowin,
  output logic                        ms_allowin,
  input  logic                        es_to_ms_valid,
  input  logic [`ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  input  logic [31:0]                 data_sram_rdata,
  output logic                        ms_to_ws_valid,
  output logic [`MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  output logic [31:0]                 ms_to_ds_result,
  output logic [4:0]                  ms_dest
);

  logic ms_valid_q, ms_valid_d;
  logic ms_first_q, ms_first_d;
  logic rdata_held_q, rdata_held_d;
  logic [`ES_TO_MS_BUS_WD-1:0] bus_q, bus_d;
  logic [31:0] rdata_q, rdata_d;

  logic        ms_ready_go;
  logic        accept;
  es_ms_t      ms;
  ms_ws_t      ws;
  logic [31:0] rdata;
  logic [31:0] load_data;
  logic [31:0] final_result;

  assign ms_ready_go = 1'b1;
  assign ms_allowin  = !ms_valid_q
                    || (ms_ready_go && ws_allowin);
  assign ms_to_ws_valid = ms_valid_q && ms_ready_go;
  assign accept = es_to_ms_valid && ms_allowin;

  // SRAM output moves on with the next EXE address,
  // so a stalled load keeps its first-cycle data.
  always_comb begin
    ms_valid_d   = ms_valid_q;
    bus_d        = bus_q;
    ms_first_d   = accept;
    rdata_held_d = rdata_held_q;
    rdata_d      = rdata_q;
    if (ms_allowin) begin
      ms_valid_d = es_to_ms_valid;
    end
    if (accept) begin
      bus_d = es_to_ms_bus;
    end
    if (ms_first_q && ms_valid_q && !ws_allowin) begin
      rdata_d      = data_sram_rdata;
      rdata_held_d = 1'b1;
    end
    if (ms_valid_q && ws_allowin) begin
      rdata_held_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ms_valid_q   <= 1'b0;
      ms_first_q   <= 1'b0;
      rdata_held_q <= 1'b0;
    end else begin
      ms_valid_q   <= ms_valid_d;
      ms_first_q   <= ms_first_d;
      rdata_held_q <= rdata_held_d;
    end
  end

  always_ff @(posedge clk) begin
    bus_q   <= bus_d;
    rdata_q <= rdata_d;
  end

  assign ms    = es_ms_t'(bus_q[73:0]);
  assign rdata = rdata_held_q ? rdata_q
                              : data_sram_rdata;

  mem_stage_load_align u_align (
    .rdata     (rdata),
    .addr      (ms.alu_result[1:0]),
    .load_type (ms.load_type),
`ifdef MS_LWLR_EN
    .rt        (bus_q[105:74]),
`endif
    .load_data (load_data)
  );

  assign final_result = ms.res_from_mem ? load_data
                                        : ms.alu_result;

  assign ws.gr_we        = ms.gr_we;
  assign ws.dest         = ms.dest;
  assign ws.final_result = final_result;
  assign ws.pc           = ms.pc;
  assign ms_to_ws_bus    = ws;

  assign ms_to_ds_result = final_result;
  assign ms_dest = (ms_valid_q && ms.gr_we) ? ms.dest
                                            : 5'd0;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed plan cases plus random
// traffic against a queue-free single-slot behavioural model.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic ws_allowin;
  logic ms_allowin;
  logic es_to_ms_valid;
  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus;
  logic [31:0] data_sram_rdata;
  logic ms_to_ws_valid;
  logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus;
  logic [31:0] ms_to_ds_result;
  logic [4:0]  ms_dest;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk             (clk),
    .reset           (reset),
    .ws_allowin      (ws_allowin),
    .ms_allowin      (ms_allowin),
    .es_to_ms_valid  (es_to_ms_valid),
    .es_to_ms_bus    (es_to_ms_bus),
    .data_sram_rdata (data_sram_rdata),
    .ms_to_ws_valid  (ms_to_ws_valid),
    .ms_to_ws_bus    (ms_to_ws_bus),
    .ms_to_ds_result (ms_to_ds_result),
    .ms_dest         (ms_dest)
  );

  typedef struct {
    logic [2:0]  lt;
    logic        rfm;
    logic        we;
    logic [4:0]  dest;
    logic [31:0] alu;
    logic [31:0] pc;
    logic [31:0] rdata;
    logic [31:0] rt;
  } ins_t;

  int   total = 0;
  int   bad   = 0;
  ins_t cur;
  bit   cur_v = 0;
  bit   cur_first = 0;
  bit   fixed_junk = 0;
  logic [31:0] junk = 32'h0;
  logic [32:0] none = 33'h0;

  function automatic logic [31:0] ref_res(ins_t i);
    longint unsigned r, rt, b, h, res;
    int unsigned a, n;
    r  = longint'(i.rdata);
    rt = longint'(i.rt);
    a  = i.alu % 4;
    b  = (r >> (8 * a)) & 255;
    h  = (r >> (16 * (a / 2))) & 65535;
    if (!i.rfm) return i.alu;
    res = r;
    case (i.lt)
      3'd1: res = (b >= 128) ? b + 64'hFFFFFF00 : b;
      3'd2: res = b;
      3'd3: res = (h >= 32768) ? h + 64'hFFFF0000 : h;
      3'd4: res = h;
`ifdef MS_LWLR_EN
      3'd5: begin
        n = 8 * (3 - a);
        res = (r << n) | (rt & ((64'd1 << n) - 1));
      end
      3'd6: begin
        n = 8 * a;
        res = (r >> n)
            | (rt & ~(64'hFFFFFFFF >> n));
      end
`endif
      default: res = r;
    endcase
    return 32'(res & 64'hFFFFFFFF);
  endfunction

  function automatic logic [ES_TO_MS_BUS_WD-1:0]
      pack(ins_t i);
`ifdef MS_LWLR_EN
    return {i.rt, i.lt, i.rfm, i.we,
            i.dest, i.alu, i.pc};
`else
    return {i.lt, i.rfm, i.we,
            i.dest, i.alu, i.pc};
`endif
  endfunction

  function automatic ins_t mk(
      logic [2:0] lt, logic rfm, logic we,
      logic [4:0] dest, logic [31:0] alu,
      logic [31:0] rdata, logic [31:0] rt);
    ins_t i;
    i.lt = lt; i.rfm = rfm; i.we = we;
    i.dest = dest; i.alu = alu;
    i.pc = $urandom; i.rdata = rdata; i.rt = rt;
    return i;
  endfunction

  function automatic ins_t rnd();
    return mk(3'($urandom % 8), 1'($urandom % 4 != 0),
              1'($urandom % 2), 5'($urandom),
              $urandom, $urandom, $urandom);
  endfunction

  task automatic chk(input string tag,
                     input logic [69:0] obs,
                     input logic [69:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  // Called #1 after a posedge; returns #1 after the next one.
  task automatic cycle(input bit ev, input ins_t nx,
                       input bit wa, input logic [32:0] want);
    logic [31:0] r;
    es_to_ms_valid = ev;
    es_to_ms_bus   = pack(nx);
    ws_allowin     = wa;
    data_sram_rdata = (cur_v && cur_first) ? cur.rdata
                    : (fixed_junk ? junk : $urandom);
    @(negedge clk);
    chk("allowin", 70'(ms_allowin), 70'(!cur_v || wa));
    chk("ws_valid", 70'(ms_to_ws_valid), 70'(cur_v));
    chk("dest", 70'(ms_dest),
        70'((cur_v && cur.we) ? cur.dest : 5'd0));
    if (cur_v) begin
      r = ref_res(cur);
      chk("ws_bus", 70'(ms_to_ws_bus),
          {cur.we, cur.dest, r, cur.pc});
      chk("bypass", 70'(ms_to_ds_result), 70'(r));
    end
    if (want[32])
      chk("want", 70'(ms_to_ws_bus[63:32]), 70'(want[31:0]));
    @(posedge clk);
    if (!cur_v || wa) begin
      cur_first = ev;
      cur_v     = ev;
      if (ev) cur = nx;
    end else begin
      cur_first = 0;
    end
    #1;
  endtask

  ins_t i0, i1;

  initial begin
    reset = 1'b1;
    ws_allowin = 1'b1;
    es_to_ms_valid = 1'b0;
    es_to_ms_bus = '0;
    data_sram_rdata = '0;
    cur = mk(0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    chk("rst_valid", 70'(ms_to_ws_valid), 70'(0));
    chk("rst_allowin", 70'(ms_allowin), 70'(1));
    chk("rst_dest", 70'(ms_dest), 70'(0));
    @(posedge clk); #1;

    i0 = mk(`LD_LW, 1, 1, 5'd7, 32'h100,
            32'hDEADBEEF, 0);
    cycle(1, i0, 1, none);
    chk("lw_dest", 70'(ms_dest), 70'(7));
    cycle(0, i0, 1, {1'b1, 32'hDEADBEEF});

    i0 = mk(`LD_LB, 1, 1, 5'd3, 32'h103,
            32'h80123456, 0);
    cycle(1, i0, 1, none);
    i0.lt = `LD_LBU;
    cycle(1, i0, 1, {1'b1, 32'hFFFFFF80});
    i0.lt = `LD_LH; i0.alu = 32'h102;
    cycle(1, i0, 1, {1'b1, 32'h00000080});
    i0.lt = `LD_LHU;
    cycle(1, i0, 1, {1'b1, 32'hFFFF8012});
    cycle(0, i0, 1, {1'b1, 32'h00008012});

    i0 = mk(`LD_LW, 1, 1, 5'd9, 32'h200,
            32'hCAFEF00D, 0);
    cycle(1, i0, 1, none);
    fixed_junk = 1; junk = 32'h11111111;
    cycle(0, i0, 0, {1'b1, 32'hCAFEF00D});
    cycle(0, i0, 0, {1'b1, 32'hCAFEF00D});
    cycle(0, i0, 0, {1'b1, 32'hCAFEF00D});
    cycle(0, i0, 1, {1'b1, 32'hCAFEF00D});
    fixed_junk = 0;

    i0 = mk(`LD_LW, 0, 0, 5'd4, 32'h5, 0, 0);
    i1 = mk(`LD_LW, 1, 1, 5'd5, 32'h300,
            32'h12345678, 0);
    cycle(1, i0, 1, none);
    chk("b2b_dest0", 70'(ms_dest), 70'(0));
    cycle(1, i1, 1, {1'b1, 32'h5});
    cycle(0, i1, 1, {1'b1, 32'h12345678});

`ifdef MS_LWLR_EN
    i0 = mk(`LD_LWL, 1, 1, 5'd6, 32'h401,
            32'hAABBCCDD, 32'h11223344);
    cycle(1, i0, 1, none);
    i0.lt = `LD_LWR;
    cycle(1, i0, 1, {1'b1, 32'hCCDD3344});
    cycle(0, i0, 1, {1'b1, 32'h11AABBCC});
`endif

    i0 = mk(`LD_LW, 1, 1, 5'd8, 32'h500,
            32'h0BADF00D, 0);
    cycle(1, i0, 1, none);
    cycle(0, i0, 0, none);
    reset = 1'b1;
    es_to_ms_valid = 1'b0;
    ws_allowin = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    cur_v = 0; cur_first = 0;
    @(negedge clk);
    chk("rst2_valid", 70'(ms_to_ws_valid), 70'(0));
    chk("rst2_allowin", 70'(ms_allowin), 70'(1));
    chk("rst2_dest", 70'(ms_dest), 70'(0));
    @(posedge clk); #1;

    for (int k = 0; k < 400; k++) begin
      cycle(1'($urandom % 4 != 0), rnd(),
            1'($urandom % 3 != 0), none);
    end
    cycle(0, rnd(), 1, none);
    cycle(0, rnd(), 1, none);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory stage of the 5-stage MIPS pipeline.
- Receives the EXE→MEM bus and the synchronous data SRAM read data; it is the consumer end of the EXE-driven data SRAM interface.
- Extracts, aligns and extends load data, selects the final result, and presents it to WB with valid/allowin handshake.
- Exports a bypass result and destination to the decode stage.

Parameters:
- None. Bus widths come from shared header macros `ES_TO_MS_BUS_WD` (74, or 106 with `MS_LWLR_EN`) and `MS_TO_WS_BUS_WD` (70).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- ws_allowin  in  1  WB can accept
- ms_allowin  out  1  MEM can accept
- es_to_ms_valid  in  1  EXE bus valid
- es_to_ms_bus  in  `ES_TO_MS_BUS_WD`  {[105:74] rt_value (`MS_LWLR_EN` only), load_type[73:71], res_from_mem[70], gr_we[69], dest[68:64], alu_result[63:32], pc[31:0]}
- data_sram_rdata  in  32  SRAM read data, valid the cycle after EXE presents the address
- ms_to_ws_valid  out  1  WB bus valid
- ms_to_ws_bus  out  `MS_TO_WS_BUS_WD`  {gr_we[69], dest[68:64], final_result[63:32], pc[31:0]}
- ms_to_ds_result  out  32  bypass value (final_result)
- ms_dest  out  5  bypass destination; 0 when !ms_valid or !gr_we

Behaviour:
- Clocking and reset: clk only; reset is synchronous and active-high.
  - On reset: ms_valid=0 and rdata_held=0, so ms_to_ws_valid=0, ms_dest=0 and ms_allowin=1.
  - Bus and data registers are not reset.
- Handshake:
  - ms_ready_go=1.
  - ms_allowin = !ms_valid || (ms_ready_go && ws_allowin).
  - ms_to_ws_valid = ms_valid && ms_ready_go.
  - When ms_allowin=1: ms_valid <= es_to_ms_valid.
  - When es_to_ms_valid && ms_allowin: bus_r <= es_to_ms_bus.
- Read-data capture (SRAM output follows the next EXE address, so MEM must hold its own copy):
  - ms_first sets on acceptance and clears the following cycle.
  - In a cycle with ms_first=1 && ms_valid && !ws_allowin: rdata_r <= data_sram_rdata and rdata_held <= 1.
  - rdata_held clears on handoff (ms_valid && ws_allowin) or on reset.
  - Effective rdata = rdata_held ? rdata_r : data_sram_rdata.
  - A stall of any length must produce the same WB result as no stall.
- Load extraction, with a = alu_result[1:0]:
  - type 0 LW: rdata.
  - type 1 LB: sign-extend of byte a.
  - type 2 LBU: zero-extend of byte a.
  - type 3 LH: sign-extend of half a[1].
  - type 4 LHU: zero-extend of half a[1].
  - Alignment faults are not checked here; for LH/LHU, a[0] is ignored.
- final_result = res_from_mem ? load_data : alu_result.
- Back-to-back:
  - A new instruction is accepted in the same cycle the old one hands off.
  - ms_first re-arms for the new instruction; rdata_held is cleared in that same cycle.
- Bypass: ms_to_ds_result = final_result, combinational from current state.
- Reset mid-stall: the held instruction is dropped and no WB valid is issued.
- Undefined load_type 5–7 without `MS_LWLR_EN`: load_data = rdata.

Optional Feature:
- Macro: `MS_LWLR_EN`.
- When defined:
  - The bus carries rt_value at [105:74].
  - type 5 LWL merges rdata high bytes into rt: a=0 {rdata[7:0],rt[23:0]}; a=1 {rdata[15:0],rt[15:0]}; a=2 {rdata[23:0],rt[7:0]}; a=3 rdata.
  - type 6 LWR: a=0 rdata; a=1 {rt[31:24],rdata[31:8]}; a=2 {rt[31:16],rdata[31:16]}; a=3 {rt[31:8],rdata[31:24]}.
- When undefined: the field and both types are absent; the bus is 74 bits.

Decomposition:
- Shared header mycpu.h holds:
  - bus width macros;
  - load_type encodings `LD_LW`=0 .. `LD_LWR`=6;
  - the `MS_LWLR_EN` default.
- Natural sub-module: load_align (combinational; inputs rdata, addr[1:0], load_type, rt; output load_data). The handshake and capture logic stays in mem_stage.

Test Plan:
- LW, no stall: bus alu_result=0x100, rdata=0xDEADBEEF in the following cycle → WB result 0xDEADBEEF one cycle after acceptance; ms_dest equals dest.
- LB a=3 with rdata=0x80123456 → 0xFFFFFF80. LBU same → 0x00000080. LH a=2 → 0xFFFF8012. LHU → 0x00008012.
- Stall: LW accepted, ws_allowin=0 for 3 cycles, rdata changes to 0x11111111 after the first cycle → WB still gets the first-cycle value 0xCAFEF00D; ms_allowin=0 throughout the stall.
- Back-to-back: ALU op (res_from_mem=0, result 0x5) followed by LW, ws_allowin=1 → consecutive WB results 0x5 then the LW data; no bubble; ms_dest=0 when gr_we=0.
- Reset asserted while an instruction is stalled → next cycle ms_to_ws_valid=0, ms_allowin=1, ms_dest=0.
- `MS_LWLR_EN`: LWL a=1, rdata=0xAABBCCDD, rt=0x11223344 → 0xCCDD3344. LWR a=1 → 0x11AABBCC.
